l2k_marb: RTL
=============

# l2k_marb

Round-robin memory arbiter that shares the single external RAM port (addr/data/rdy/we/ce) of the Limn2600 CPU between NUM_CLIENTS requesters (cores, MMU walker, etc.). One transaction is in flight at a time. Byte and halfword writes are performed as read-modify-write word cycles, and byte/halfword reads are lane-extracted and zero-extended. The block sits between the per-core memory schedulers and the MMU address path at the top of the CPU.

## Interface
- NUM_CLIENTS, 4, number of requesters (2..8)
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_CLIENTS  per-client request; held high with fields stable until that client's req_done
- req_we  in  NUM_CLIENTS  1 = write, 0 = read
- req_addr  in  32*NUM_CLIENTS  byte address; client i occupies bits [32i+31:32i]
- req_size  in  2*NUM_CLIENTS  0 = byte, 1 = half, 2/3 = word
- req_wdata  in  32*NUM_CLIENTS  write data, right-aligned for byte/half
- req_done  out  NUM_CLIENTS  one-cycle pulse on the granted client when its transaction completes
- rsp_data  out  32  read data, zero-extended; valid only in the req_done cycle
- busy  out  1  high in every state except IDLE
- ram_addr  out  32  word address to the RAM port (bits [1:0] always 0)
- ram_data_in  in  32  RAM read data, sampled when ram_rdy=1 in RD
- ram_data_out  out  32  RAM write data
- ram_rdy  in  1  RAM completes the current ce cycle
- ram_we  out  1  1 = write cycle
- ram_ce  out  1  1 = RAM cycle active

## Operation
- All outputs are registered. Reset values:
  - ram_ce=0, ram_we=0, ram_addr=0, ram_data_out=0
  - req_done=0, rsp_data=0, busy=0
  - grant pointer ptr=0, state=IDLE
- States: IDLE, RD, WR, RESP.
- **IDLE:**
  - Scan clients ptr, ptr+1, … (mod NUM_CLIENTS). The first client with valid=1 becomes grant g.
  - Latch that client's addr, size, we, and wdata.
  - If the request is a read, or a write with size<2: go to RD with ce=1, we=0, ram_addr={addr[31:2],2'b00}.
  - If the request is a word write: go to WR with ce=1, we=1, ram_data_out=wdata.
  - If no client is valid: stay in IDLE.
- **RD**, waiting for ram_rdy:
  - Read completion: on ram_rdy, extract the data and go to RESP with ce=0.
    - Byte: lane addr[1:0], bits [8k+7:8k].
    - Half: lane addr[1], bits [16k+15:16k]; addr[0] is ignored.
    - Word: the full word.
  - Write merge: on ram_rdy, merge into ram_data_in and go to WR with ce=1, we=1.
    - Byte write replaces byte lane addr[1:0] with wdata[7:0].
    - Half write replaces half lane addr[1] with wdata[15:0].
- **WR:** wait for ram_rdy, then go to RESP with ce=0, we=0.
- **RESP:**
  - req_done[g]=1 for one cycle; rsp_data holds the read result, or is unchanged for writes.
  - ptr ← (g+1) mod NUM_CLIENTS; next state IDLE.
- A transaction always runs to completion once granted. Dropping req_valid mid-transaction does not abort it, and req_done[g] still pulses.
- The latched request fields are used throughout. Changes on req_* after the grant are ignored until the next IDLE.
- rst asserted in any state: at the next edge, state=IDLE, ce=0, we=0, and no done pulse. A partially completed RMW is abandoned; the RAM word is unmodified because WR was never entered.

## Timing
- ram_rdy is sampled on every edge while in RD or WR, including the first cycle ce is high. A RAM cycle therefore takes a minimum of 1 cycle.
- Request sampled in IDLE at edge N: ce is high during cycle N+1.
  - Read or word write with immediate rdy: req_done during cycle N+2.
  - Sub-word write with immediate rdy: RD in N+1, WR in N+2, req_done in N+3.
- ram_ce stays high continuously from RD into WR during an RMW. ram_we rises at the RD→WR edge.
- The earliest re-grant is the edge ending RESP. The minimum spacing between back-to-back transactions is 3 cycles (read/word write) or 4 cycles (sub-word write).
- Starvation bound: a continuously valid client is granted within NUM_CLIENTS transactions.
- Simultaneous valid on all clients: grant order ptr, ptr+1, …; no client is granted twice before all others are served.

## Test plan
- Reset: hold rst 2 cycles with all req_valid=1 → ram_ce=0, req_done=0, busy=0. After release, client 0 is granted first.
- Word read: client 1 reads 0x00001004, ram_rdy=1, ram_data_in=0xDEADBEEF → ram_addr=0x00001004, we=0. req_done=4'b0010 two cycles later with rsp_data=0xDEADBEEF.
- Byte RMW: client 2 writes byte 0xAA to 0x00000103, RAM word 0x11223344, rdy delayed 3 cycles per phase → read at 0x00000100, then write 0xAA223344. req_done[2] pulses once, after both phases.
- Half read: read addr 0x00000202, RAM word 0xCAFEBABE → rsp_data=0x0000CAFE.
- Round-robin: all 4 clients are valid continuously for 8 transactions → grant order 0,1,2,3,0,1,2,3. Each req_done is one cycle, and transactions are exactly 3 cycles apart with rdy=1.
- Reset mid-RMW: rst asserted in RD of a byte write → ce drops at the next edge, no WR cycle is issued, and no done pulse occurs. After release, the pending valid client is re-granted from ptr=0.

Source files
------------

// File: rtl/l2k_marb.sv
// l2k_marb: round-robin arbiter sharing the single Limn2600 RAM port among
// NUM_CLIENTS requesters. One transaction is in flight at a time. Sub-word
// writes become a read-modify-write of the containing word. Sub-word reads
// are lane-extracted and zero-extended.
//
//   state  | meaning
//   IDLE   | scanning clients from ptr, no RAM cycle active
//   RD     | RAM read cycle (plain read, or read phase of an RMW)
//   WR     | RAM write cycle (word write, or write phase of an RMW)
//   RESP   | req_done pulses on the granted client, ptr advances past it
module l2k_marb #(
    parameter int NUM_CLIENTS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CLIENTS-1:0]    req_valid,
    input  logic [NUM_CLIENTS-1:0]    req_we,
    input  logic [32*NUM_CLIENTS-1:0] req_addr,
    input  logic [2*NUM_CLIENTS-1:0]  req_size,
    input  logic [32*NUM_CLIENTS-1:0] req_wdata,
    output logic [NUM_CLIENTS-1:0]    req_done,
    output logic [31:0]               rsp_data,
    output logic                      busy,
    output logic [31:0]               ram_addr,
    input  logic [31:0]               ram_data_in,
    output logic [31:0]               ram_data_out,
    input  logic                      ram_rdy,
    output logic                      ram_we,
    output logic                      ram_ce
);

    localparam int IW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} state_t;

    state_t state, state_nxt;

    logic [IW-1:0]          ptr, ptr_nxt;
    logic [IW-1:0]          g, g_nxt;
    logic [1:0]             l_lane, l_lane_nxt;
    logic [1:0]             l_size, l_size_nxt;
    logic                   l_we, l_we_nxt;
    logic [15:0]            l_wdata, l_wdata_nxt;

    logic [NUM_CLIENTS-1:0] done_nxt;
    logic [31:0]            rsp_nxt, addr_nxt, dout_nxt;
    logic                   busy_nxt, we_nxt, ce_nxt;

    logic                   found;
    logic [IW-1:0]          sel;
    logic [31:0]            sel_addr, sel_wdata;
    logic [1:0]             sel_size;
    logic                   sel_we;

    // (base + off) mod NUM_CLIENTS, off < NUM_CLIENTS
    function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_CLIENTS) s = s - NUM_CLIENTS;
        return IW'(s);
    endfunction

    // Pick the addressed lane out of a RAM word, zero-extended
    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] lane,
                                            input logic [1:0] sz);
        logic [31:0] r;
        if (sz[1])      r = w;
        else if (sz[0]) r = {16'h0000, w[{lane[1], 4'b0000} +: 16]};
        else            r = {24'h000000, w[{lane, 3'b000} +: 8]};
        return r;
    endfunction

    // Overlay the sub-word write data onto the word just read
    function automatic logic [31:0] merge(input logic [31:0] w, input logic [1:0] lane,
                                          input logic [1:0] sz, input logic [15:0] wd);
        logic [31:0] r;
        r = w;
        if (sz[0]) r[{lane[1], 4'b0000} +: 16] = wd;
        else       r[{lane, 3'b000} +: 8]      = wd[7:0];
        return r;
    endfunction

    // Round-robin scan starting at ptr; descending loop so the lowest offset wins
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int k = NUM_CLIENTS - 1; k >= 0; k--) begin
            if (req_valid[wrap_idx(ptr, k)]) begin
                found = 1'b1;
                sel   = wrap_idx(ptr, k);
            end
        end
        sel_addr  = req_addr[32*sel +: 32];
        sel_wdata = req_wdata[32*sel +: 32];
        sel_size  = req_size[2*sel +: 2];
        sel_we    = req_we[sel];
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (found)   state_nxt = (sel_we && sel_size[1]) ? S_WR : S_RD;
            S_RD:   if (ram_rdy) state_nxt = l_we ? S_WR : S_RESP;
            S_WR:   if (ram_rdy) state_nxt = S_RESP;
            S_RESP:              state_nxt = S_IDLE;
            default:             state_nxt = S_IDLE;
        endcase
    end

    // Next values of the registered outputs and latched request fields
    always_comb begin
        ptr_nxt     = ptr;
        g_nxt       = g;
        l_lane_nxt  = l_lane;
        l_size_nxt  = l_size;
        l_we_nxt    = l_we;
        l_wdata_nxt = l_wdata;
        done_nxt    = '0;
        rsp_nxt     = rsp_data;
        addr_nxt    = ram_addr;
        dout_nxt    = ram_data_out;
        we_nxt      = ram_we;
        ce_nxt      = ram_ce;
        busy_nxt    = (state_nxt != S_IDLE);
        case (state)
            S_IDLE: begin
                if (found) begin
                    g_nxt       = sel;
                    l_lane_nxt  = sel_addr[1:0];
                    l_size_nxt  = sel_size;
                    l_we_nxt    = sel_we;
                    l_wdata_nxt = sel_wdata[15:0];
                    addr_nxt    = {sel_addr[31:2], 2'b00};
                    ce_nxt      = 1'b1;
                    if (sel_we && sel_size[1]) begin
                        we_nxt   = 1'b1;
                        dout_nxt = sel_wdata;
                    end else begin
                        we_nxt   = 1'b0;
                    end
                end
            end
            S_RD: begin
                if (ram_rdy) begin
                    if (l_we) begin
                        // ce stays high straight into the write phase
                        we_nxt   = 1'b1;
                        dout_nxt = merge(ram_data_in, l_lane, l_size, l_wdata);
                    end else begin
                        ce_nxt      = 1'b0;
                        rsp_nxt     = extract(ram_data_in, l_lane, l_size);
                        done_nxt[g] = 1'b1;
                    end
                end
            end
            S_WR: begin
                if (ram_rdy) begin
                    ce_nxt      = 1'b0;
                    we_nxt      = 1'b0;
                    done_nxt[g] = 1'b1;
                end
            end
            S_RESP: begin
                ptr_nxt = wrap_idx(g, 1);
            end
            default: ;
        endcase
    end

    // Output and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr          <= '0;
            g            <= '0;
            l_lane       <= '0;
            l_size       <= '0;
            l_we         <= 1'b0;
            l_wdata      <= '0;
            req_done     <= '0;
            rsp_data     <= '0;
            busy         <= 1'b0;
            ram_addr     <= '0;
            ram_data_out <= '0;
            ram_we       <= 1'b0;
            ram_ce       <= 1'b0;
        end else begin
            ptr          <= ptr_nxt;
            g            <= g_nxt;
            l_lane       <= l_lane_nxt;
            l_size       <= l_size_nxt;
            l_we         <= l_we_nxt;
            l_wdata      <= l_wdata_nxt;
            req_done     <= done_nxt;
            rsp_data     <= rsp_nxt;
            busy         <= busy_nxt;
            ram_addr     <= addr_nxt;
            ram_data_out <= dout_nxt;
            ram_we       <= we_nxt;
            ram_ce       <= ce_nxt;
        end
    end

endmodule
